// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the fetch front end: FSM states, redirect sources,
// and the default width/reset-vector constants.
package pc_fetch_unit_pkg;

    localparam int          DEF_XLEN      = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BR   = 2'd1,
        SRC_JMP  = 2'd2,
        SRC_TRAP = 2'd3
    } redir_src_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect priority select (trap > jump > branch) with target alignment, plus the
// pending-redirect register that holds a redirect raised while a request waits for ready.
// PC_MISALIGN_TRAP_EN: misaligned targets become TRAP_VEC instead of being truncated.
module pc_redirect_arb
    import pc_fetch_unit_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VEC = 'h10
`endif
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_trap_en,
    input  logic [XLEN-1:0] i_trap_target,
    input  logic            i_jump_en,
    input  logic [XLEN-1:0] i_jump_target,
    input  logic            i_branch_en,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic            i_capture,
    input  logic            i_clear,
    output logic            o_sel_valid,
    output logic [XLEN-1:0] o_sel_target,
    output logic            o_sel_misalign,
    output logic            o_pend_valid,
    output logic [XLEN-1:0] o_pend_target,
    output logic            o_pend_misalign
);

    redir_src_t      sel_src;
    logic [XLEN-1:0] raw_target;
    redir_src_t      pend_src;
    logic [XLEN-1:0] pend_target;
    logic            pend_misalign;

    always_comb begin
        sel_src    = SRC_NONE;
        raw_target = '0;
        if (i_trap_en) begin
            sel_src    = SRC_TRAP;
            raw_target = i_trap_target;
        end else if (i_jump_en) begin
            sel_src    = SRC_JMP;
            raw_target = i_jump_target;
        end else if (i_branch_en) begin
            sel_src    = SRC_BR;
            raw_target = i_branch_target;
        end
    end

    always_comb begin
        o_sel_valid = (sel_src != SRC_NONE);
`ifdef PC_MISALIGN_TRAP_EN
        o_sel_misalign = o_sel_valid && (raw_target[1:0] != 2'b00);
        o_sel_target   = o_sel_misalign ? TRAP_VEC : raw_target;
`else
        o_sel_misalign = 1'b0;
        o_sel_target   = raw_target & ~XLEN'(3);
`endif
    end

    // A buffered trap is never displaced by a later jump or branch.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            pend_src      <= SRC_NONE;
            pend_target   <= '0;
            pend_misalign <= 1'b0;
        end else if (i_capture && o_sel_valid &&
                     !(pend_src == SRC_TRAP && sel_src != SRC_TRAP)) begin
            pend_src      <= sel_src;
            pend_target   <= o_sel_target;
            pend_misalign <= o_sel_misalign;
        end
    end

    assign o_pend_valid    = (pend_src != SRC_NONE);
    assign o_pend_target   = pend_target;
    assign o_pend_misalign = pend_misalign;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register, hold/fetch/stall sequencer and accepted-fetch counter.
// PC_MISALIGN_TRAP_EN selects trapping on misaligned redirect targets.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter int              INCR      = 4,
    parameter int              RST_HOLD  = 2
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VEC  = 'h10
`endif
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_trap_en,
    input  logic [XLEN-1:0] i_trap_target,
    input  logic            i_jump_en,
    input  logic [XLEN-1:0] i_jump_target,
    input  logic            i_branch_en,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic            i_imem_ready,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus,
    output logic            o_squash,
    output logic [XLEN-1:0] o_fetch_count,
    output logic            o_misalign
);

    localparam int               HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_INIT = HW'(RST_HOLD - 1);

    fetch_state_t    state, next_state;
    logic [HW-1:0]   hold_cnt;
    logic            fetch_req;
    logic            accept;
    logic            sel_valid, sel_misalign;
    logic [XLEN-1:0] sel_target;
    logic            pend_valid, pend_misalign;
    logic [XLEN-1:0] pend_target;
    logic            misalign_q;

    pc_redirect_arb #(
        .XLEN(XLEN)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .TRAP_VEC(TRAP_VEC)
`endif
    ) u_arb (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_trap_en       (i_trap_en),
        .i_trap_target   (i_trap_target),
        .i_jump_en       (i_jump_en),
        .i_jump_target   (i_jump_target),
        .i_branch_en     (i_branch_en),
        .i_branch_target (i_branch_target),
        .i_capture       (o_imem_req && !i_imem_ready),
        .i_clear         (accept),
        .o_sel_valid     (sel_valid),
        .o_sel_target    (sel_target),
        .o_sel_misalign  (sel_misalign),
        .o_pend_valid    (pend_valid),
        .o_pend_target   (pend_target),
        .o_pend_misalign (pend_misalign)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_INIT;
        end else begin
            state <= next_state;
            if (state == S_HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Valid/ready: once o_imem_req is high it stays high, with o_pc unchanged,
    // until the cycle i_imem_ready is also high; that cycle is the accept.
    always_comb begin
        next_state = state;
        fetch_req  = 1'b0;
        case (state)
            S_HOLD:  if (hold_cnt == '0) next_state = S_FETCH;
            S_FETCH: begin
                fetch_req = 1'b1;
                if (i_stall && i_imem_ready) next_state = S_STALL;
            end
            S_STALL: if (!i_stall) next_state = S_FETCH;
            default: next_state = S_HOLD;
        endcase
    end

    assign o_imem_req = fetch_req && !i_rst;
    assign accept     = o_imem_req && i_imem_ready;
    assign o_squash   = accept && pend_valid;
    assign o_pc_plus  = o_pc + XLEN'(INCR);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pc          <= RESET_VEC;
            o_fetch_count <= '0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (accept) begin
                o_fetch_count <= o_fetch_count + XLEN'(1);
                if (sel_valid) begin
                    o_pc       <= sel_target;
                    misalign_q <= sel_misalign;
                end else if (pend_valid) begin
                    o_pc       <= pend_target;
                    misalign_q <= pend_misalign;
                end else begin
                    o_pc <= o_pc_plus;
                end
            end else if (!o_imem_req && sel_valid) begin
                o_pc       <= sel_target;
                misalign_q <= sel_misalign;
            end
        end
    end

    assign o_misalign = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: accepted fetches are scoreboarded as {squash, pc}.
module tb_pc_fetch_unit;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] TRAP_VEC_EXP = 32'h10;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            trap_en, jump_en, branch_en;
    logic [XLEN-1:0] trap_target, jump_target, branch_target;
    logic            imem_ready;
    logic            imem_req;
    logic [XLEN-1:0] pc, pc_plus, fetch_count;
    logic            squash, misalign;

    int errors = 0;
    int checks = 0;
    logic [XLEN:0] exp_q[$];

    pc_fetch_unit dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_trap_en       (trap_en),
        .i_trap_target   (trap_target),
        .i_jump_en       (jump_en),
        .i_jump_target   (jump_target),
        .i_branch_en     (branch_en),
        .i_branch_target (branch_target),
        .i_imem_ready    (imem_ready),
        .o_imem_req      (imem_req),
        .o_pc            (pc),
        .o_pc_plus       (pc_plus),
        .o_squash        (squash),
        .o_fetch_count   (fetch_count),
        .o_misalign      (misalign)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted request must match the oldest expected {squash, pc}.
    always @(negedge clk) begin
        if (!rst && imem_req && imem_ready) begin
            logic [XLEN:0] exp_v;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL accept_unexpected: got squash=%0b pc=%h, expected no accept", squash, pc);
            end else begin
                exp_v = exp_q.pop_front();
                if ({squash, pc} !== exp_v) begin
                    errors++;
                    $display("FAIL accept_pc: got squash=%0b pc=%h, expected squash=%0b pc=%h",
                             squash, pc, exp_v[XLEN], exp_v[XLEN-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        trap_en = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
    endtask

    task automatic push(input logic sq, input logic [XLEN-1:0] p);
        exp_q.push_back({sq, p});
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending accepts, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ready = 1'b0; stall = 1'b0;
        clear_redirects();
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 10 && !imem_req; i++) tick();
        checks++;
        if (!imem_req || pc !== 32'h0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_restart: got req=%0b pc=%h count=%0d, expected req=1 pc=0 count=0",
                     imem_req, pc, fetch_count);
        end
    endtask

    task automatic accept_n(input int n);
        imem_ready = 1'b1;
        repeat (n) tick();
        imem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b1; stall = 1'b0;
        trap_target = '0; jump_target = '0; branch_target = '0;
        clear_redirects();
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || fetch_count !== 32'h0 ||
            squash !== 1'b0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pc=%h req=%0b count=%0d squash=%0b mis=%0b, expected all 0",
                     pc, imem_req, fetch_count, squash, misalign);
        end
        push(0, 32'h0); push(0, 32'h4); push(0, 32'h8); push(0, 32'hC);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL hold_req_%0d: got req=%0b, expected 0", i, imem_req);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL first_req: got req=%0b, expected 1", imem_req);
        end
        tick();
        repeat (3) tick();
        imem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_count !== 32'd4 || pc !== 32'h10) begin
            errors++;
            $display("FAIL seq_count: got count=%0d pc=%h, expected count=4 pc=10", fetch_count, pc);
        end
        check_drained("reset");
    endtask

    task automatic test_hold_redirect();
        rst = 1'b1; imem_ready = 1'b0; clear_redirects();
        repeat (2) tick();
        rst = 1'b0;
        jump_en = 1'b1; jump_target = 32'h60;
        tick();
        clear_redirects();
        @(negedge clk);
        checks++;
        if (pc !== 32'h60 || imem_req !== 1'b0 || squash !== 1'b0) begin
            errors++;
            $display("FAIL hold_redirect: got pc=%h req=%0b squash=%0b, expected pc=60 req=0 squash=0",
                     pc, imem_req, squash);
        end
    endtask

    task automatic test_ready_hold();
        do_reset();
        push(0, 32'h0); push(0, 32'h4);
        accept_n(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pc !== 32'h8 || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL ready_hold_%0d: got pc=%h req=%0b, expected pc=8 req=1", i, pc, imem_req);
            end
            tick();
        end
        push(0, 32'h8);
        accept_n(1);
        @(negedge clk);
        checks++;
        if (pc !== 32'hC) begin
            errors++;
            $display("FAIL ready_release: got pc=%h, expected C", pc);
        end
        check_drained("ready_hold");
    endtask

    task automatic test_branch_pending();
        do_reset();
        push(0, 32'h0); push(0, 32'h4);
        accept_n(2);
        branch_en = 1'b1; branch_target = 32'h40;
        tick();
        clear_redirects();
        tick();
        @(negedge clk);
        checks++;
        if (pc !== 32'h8 || squash !== 1'b0) begin
            errors++;
            $display("FAIL pending_hold: got pc=%h squash=%0b, expected pc=8 squash=0", pc, squash);
        end
        push(1, 32'h8);
        accept_n(1);
        @(negedge clk);
        checks++;
        if (pc !== 32'h40 || squash !== 1'b0 || fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL pending_apply: got pc=%h squash=%0b count=%0d, expected pc=40 squash=0 count=3",
                     pc, squash, fetch_count);
        end
        check_drained("branch_pending");
    endtask

    task automatic test_priority();
        do_reset();
        trap_en = 1'b1; trap_target = 32'h100;
        jump_en = 1'b1; jump_target = 32'h80;
        branch_en = 1'b1; branch_target = 32'h40;
        push(0, 32'h0);
        accept_n(1);
        clear_redirects();
        @(negedge clk);
        checks++;
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL prio_trap: got pc=%h, expected 100", pc);
        end
        jump_en = 1'b1; branch_en = 1'b1;
        push(0, 32'h100);
        accept_n(1);
        clear_redirects();
        @(negedge clk);
        checks++;
        if (pc !== 32'h80) begin
            errors++;
            $display("FAIL prio_jump: got pc=%h, expected 80", pc);
        end
        trap_en = 1'b1; trap_target = 32'h200;
        tick();
        clear_redirects();
        jump_en = 1'b1; jump_target = 32'h300;
        tick();
        clear_redirects();
        push(1, 32'h80);
        accept_n(1);
        @(negedge clk);
        checks++;
        if (pc !== 32'h200) begin
            errors++;
            $display("FAIL pending_trap_kept: got pc=%h, expected 200", pc);
        end
        check_drained("priority");
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || pc !== 32'h0) begin
                errors++;
                $display("FAIL stall_hold_%0d: got req=%0b pc=%h, expected req=1 pc=0", i, imem_req, pc);
            end
        end
        push(0, 32'h0);
        accept_n(1);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h4) begin
            errors++;
            $display("FAIL stall_enter: got req=%0b pc=%h, expected req=0 pc=4", imem_req, pc);
        end
        branch_en = 1'b1; branch_target = 32'h20;
        tick();
        clear_redirects();
        @(negedge clk);
        checks++;
        if (pc !== 32'h20 || squash !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_redirect: got pc=%h squash=%0b req=%0b, expected pc=20 squash=0 req=0",
                     pc, squash, imem_req);
        end
        stall = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || pc !== 32'h20) begin
            errors++;
            $display("FAIL stall_resume: got req=%0b pc=%h, expected req=1 pc=20", imem_req, pc);
        end
        push(0, 32'h20);
        accept_n(1);
        @(negedge clk);
        checks++;
        if (pc !== 32'h24) begin
            errors++;
            $display("FAIL stall_next: got pc=%h, expected 24", pc);
        end
        check_drained("stall");
    endtask

    task automatic test_misalign();
        logic [XLEN-1:0] exp_pc;
        logic            exp_mis;
`ifdef PC_MISALIGN_TRAP_EN
        exp_pc = TRAP_VEC_EXP; exp_mis = 1'b1;
`else
        exp_pc = 32'h40; exp_mis = 1'b0;
`endif
        do_reset();
        jump_en = 1'b1; jump_target = 32'h42;
        push(0, 32'h0);
        accept_n(1);
        clear_redirects();
        @(negedge clk);
        checks++;
        if (pc !== exp_pc || misalign !== exp_mis) begin
            errors++;
            $display("FAIL misalign_load: got pc=%h mis=%0b, expected pc=%h mis=%0b", pc, misalign, exp_pc, exp_mis);
        end
        tick();
        @(negedge clk);
        checks++;
        if (misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: got mis=%0b, expected 0", misalign);
        end
        check_drained("misalign");
    endtask

    task automatic test_wrap();
        do_reset();
        jump_en = 1'b1; jump_target = 32'hFFFF_FFFC;
        push(0, 32'h0);
        accept_n(1);
        clear_redirects();
        @(negedge clk);
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus !== 32'h0) begin
            errors++;
            $display("FAIL wrap_plus: got pc=%h pc_plus=%h, expected pc=FFFFFFFC pc_plus=0", pc, pc_plus);
        end
        push(0, 32'hFFFF_FFFC);
        accept_n(1);
        @(negedge clk);
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: got pc=%h, expected 0", pc);
        end
        check_drained("wrap");
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] exp_pc;
        int              n;
        do_reset();
        exp_pc = 32'h0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            imem_ready = ($urandom_range(0, 1) == 1);
            if (imem_ready) begin
                push(0, exp_pc);
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            tick();
        end
        imem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== exp_pc || fetch_count !== XLEN'(n)) begin
            errors++;
            $display("FAIL b2b_final: got pc=%h count=%0d, expected pc=%h count=%0d", pc, fetch_count, exp_pc, n);
        end
        check_drained("back_to_back");
    endtask

    initial begin
        test_reset();
        test_hold_redirect();
        test_ready_hold();
        test_branch_pending();
        test_priority();
        test_stall();
        test_misalign();
        test_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
